// File: rtl/mem_arbiter_mif.sv
// Round-robin arbiter merging NCH store/load requesters onto one single-port SRAM handshake,
// with per-channel done/err pulses and a response timeout (TIMEOUT=0 disables it).
//   state | meaning
//   IDLE  | pick next pending channel from rr pointer, latch its request
//   REQ   | one-cycle SRAM strobe, clear timeout counter
//   WAIT  | wait for mem_resp or timeout
//   DONE  | one-cycle done/err pulse on the granted channel
module mem_arbiter_mif #(
    parameter int NCH     = 2,
    parameter int DATA_W  = 16,
    parameter int ADDR_W  = 14,
    parameter int TIMEOUT = 255
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [NCH-1:0]        store,
    input  logic [NCH-1:0]        load,
    input  logic [NCH*ADDR_W-1:0] addr,
    input  logic [NCH*DATA_W-1:0] wdata,
    output logic [DATA_W-1:0]     rdata,
    output logic [NCH-1:0]        done,
    output logic [NCH-1:0]        err,
    output logic                  busy,
    output logic                  write_req,
    output logic                  read_req,
    output logic [ADDR_W-1:0]     addrout,
    output logic [DATA_W-1:0]     datatomem,
    input  logic [DATA_W-1:0]     datafrommem,
    input  logic                  mem_resp
);
    localparam int PTR_W = (NCH > 1) ? $clog2(NCH) : 1;
    localparam int CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [CNT_W-1:0] CNT_TC  = CNT_W'(TIMEOUT);
    localparam logic [PTR_W-1:0] LAST_CH = PTR_W'(NCH - 1);
    localparam bit TO_EN = (TIMEOUT != 0);

    typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_DONE} state_t;

    state_t            state_q, state_d;
    logic [PTR_W-1:0]  rr_q, rr_d, gnt_q, gnt_d, gnt_sel;
    logic              is_load_q, is_load_d, err_q, err_d, found;
    logic [ADDR_W-1:0] addr_q, addr_d, addr_sel;
    logic [DATA_W-1:0] wdata_q, wdata_d, wdata_sel, rdata_q, rdata_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [NCH-1:0]    pending;
    int                idx;

    assign pending = store | load;

    // First pending channel at or after rr_q, wrapping NCH-1 -> 0.
    always_comb begin
        found     = 1'b0;
        gnt_sel   = '0;
        idx       = 0;
        addr_sel  = '0;
        wdata_sel = '0;
        for (int k = 0; k < NCH; k++) begin
            idx = int'(rr_q) + k;
            if (idx >= NCH) idx = idx - NCH;
            if (!found && pending[idx]) begin
                found   = 1'b1;
                gnt_sel = PTR_W'(idx);
            end
        end
        for (int i = 0; i < NCH; i++) begin
            if (gnt_sel == PTR_W'(i)) begin
                addr_sel  = addr[i*ADDR_W +: ADDR_W];
                wdata_sel = wdata[i*DATA_W +: DATA_W];
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        rr_d      = rr_q;
        gnt_d     = gnt_q;
        is_load_d = is_load_q;
        err_d     = err_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        rdata_d   = rdata_q;
        cnt_d     = cnt_q;
        case (state_q)
            S_IDLE: begin
                if (found) begin
                    gnt_d     = gnt_sel;
                    is_load_d = load[gnt_sel];
                    addr_d    = addr_sel;
                    wdata_d   = wdata_sel;
                    rr_d      = (gnt_sel == LAST_CH) ? '0 : gnt_sel + 1'b1;
                    if (store[gnt_sel] && load[gnt_sel]) begin
                        err_d   = 1'b1;
                        state_d = S_DONE;
                    end else begin
                        err_d   = 1'b0;
                        state_d = S_REQ;
                    end
                end
            end
            S_REQ: begin
                cnt_d   = '0;
                state_d = S_WAIT;
            end
            S_WAIT: begin
                if (mem_resp) begin
                    if (is_load_q) rdata_d = datafrommem;
                    state_d = S_DONE;
                end else if (TO_EN && cnt_q == CNT_TC) begin
                    err_d   = 1'b1;
                    state_d = S_DONE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_DONE: state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= S_IDLE;
            rr_q      <= '0;
            gnt_q     <= '0;
            is_load_q <= 1'b0;
            err_q     <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= '0;
            rdata_q   <= '0;
            cnt_q     <= '0;
        end else begin
            state_q   <= state_d;
            rr_q      <= rr_d;
            gnt_q     <= gnt_d;
            is_load_q <= is_load_d;
            err_q     <= err_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            rdata_q   <= rdata_d;
            cnt_q     <= cnt_d;
        end
    end

    always_comb begin
        done = '0;
        err  = '0;
        for (int i = 0; i < NCH; i++) begin
            done[i] = (state_q == S_DONE) && (gnt_q == PTR_W'(i));
            err[i]  = (state_q == S_DONE) && (gnt_q == PTR_W'(i)) && err_q;
        end
    end

    assign busy      = (state_q != S_IDLE);
    assign write_req = (state_q == S_REQ) && !is_load_q;
    assign read_req  = (state_q == S_REQ) && is_load_q;
    assign addrout   = addr_q;
    assign datatomem = wdata_q;
    assign rdata     = rdata_q;

endmodule

// File: tb/tb_mem_arbiter_mif.sv
// Directed and randomized bench for mem_arbiter_mif (NCH=2, 16-bit data, TIMEOUT=4)
// against a transaction-level model of grant order, latency and rdata.
module tb_mem_arbiter_mif;
    localparam int NCH = 2;
    localparam int DW  = 16;
    localparam int AW  = 14;
    localparam int TO  = 4;

    logic              clk = 1'b0;
    logic              reset;
    logic [NCH-1:0]    store, load;
    logic [NCH*AW-1:0] addr;
    logic [NCH*DW-1:0] wdata;
    logic [DW-1:0]     rdata, datatomem, datafrommem;
    logic [NCH-1:0]    done, err;
    logic              busy, write_req, read_req, mem_resp;
    logic [AW-1:0]     addrout;

    int checks = 0;
    int failures = 0;
    int rr_m = 0;
    logic [DW-1:0] rdata_m = '0;

    mem_arbiter_mif #(.NCH(NCH), .DATA_W(DW), .ADDR_W(AW), .TIMEOUT(TO)) dut (
        .clk(clk), .reset(reset), .store(store), .load(load), .addr(addr), .wdata(wdata),
        .rdata(rdata), .done(done), .err(err), .busy(busy), .write_req(write_req),
        .read_req(read_req), .addrout(addrout), .datatomem(datatomem),
        .datafrommem(datafrommem), .mem_resp(mem_resp)
    );

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int ch, input logic st, input logic ld,
                           input logic [AW-1:0] a, input logic [DW-1:0] w);
        store[ch] = st;
        load[ch]  = ld;
        addr[ch*AW +: AW]  = a;
        wdata[ch*DW +: DW] = w;
    endtask

    // Called in an IDLE cycle with requests driven; returns in the DONE cycle.
    // delay = cycles from strobe to mem_resp; beyond TO+1 the response never arrives in time.
    task automatic txn(input int delay, input logic [NCH-1:0] keep, input bit resp_in_req,
                       input logic [DW-1:0] rd, output int g);
        logic [NCH-1:0] pend, exp_v;
        logic [AW-1:0]  ea;
        logic [DW-1:0]  ew;
        int ch, j, done_cyc;
        bit ill, ld, tmo;
        pend = store | load;
        ch = -1;
        for (int k = 0; k < NCH; k++) begin
            j = (rr_m + k) % NCH;
            if (ch < 0 && pend[j]) ch = j;
        end
        if (ch < 0) ch = 0;
        g = ch;
        rr_m = (ch + 1) % NCH;
        ill = store[ch] && load[ch];
        ld  = load[ch];
        ea  = addr[ch*AW +: AW];
        ew  = wdata[ch*DW +: DW];
        exp_v = '0;
        exp_v[ch] = 1'b1;
        chk("idle_busy", busy, 0);
        tick();
        if (ill) begin
            chk("ill_wreq", write_req, 0);
            chk("ill_rreq", read_req, 0);
            chk("ill_done", done, exp_v);
            chk("ill_err", err, exp_v);
        end else begin
            chk("req_wreq", write_req, !ld);
            chk("req_rreq", read_req, ld);
            chk("req_addr", addrout, ea);
            chk("req_wdata", datatomem, ew);
            mem_resp    = resp_in_req;
            datafrommem = DW'($urandom);
            tmo = (delay > TO + 1);
            done_cyc = tmo ? TO + 3 : delay + 2;
            for (int c = 2; c < done_cyc; c++) begin
                tick();
                chk("wait_done", done, 0);
                chk("wait_strobe", {write_req, read_req}, 0);
                chk("wait_addr", addrout, ea);
                mem_resp    = (c - 1 == delay);
                datafrommem = (c - 1 == delay) ? rd : DW'($urandom);
            end
            tick();
            mem_resp = 1'b0;
            if (!tmo && ld) rdata_m = rd;
            chk("done_vec", done, exp_v);
            chk("done_err", err, tmo ? exp_v : '0);
        end
        chk("done_rdata", rdata, rdata_m);
        if (!keep[ch]) begin
            store[ch] = 1'b0;
            load[ch]  = 1'b0;
        end
    endtask

    initial begin
        int g, r, dly;
        reset = 1'b1;
        store = '0; load = '0; addr = '0; wdata = '0;
        datafrommem = '0; mem_resp = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_rdata", rdata, 0);
        chk("rst_done", done, 0);
        chk("rst_err", err, 0);
        chk("rst_busy", busy, 0);
        chk("rst_wreq", write_req, 0);
        chk("rst_rreq", read_req, 0);
        chk("rst_addrout", addrout, 0);
        chk("rst_datatomem", datatomem, 0);
        reset = 1'b0;

        // single store, then single load, then store leaves rdata alone
        set_req(0, 1, 0, 14'h0010, 16'hBEEF);
        txn(2, '0, 0, 16'h0, g);
        chk("store_gnt", g, 0);
        tick();
        set_req(1, 0, 1, 14'h3FFF, 16'h0);
        txn(1, '0, 0, 16'h1234, g);
        chk("load_gnt", g, 1);
        chk("load_rdata", rdata, 16'h1234);
        tick();
        set_req(0, 1, 0, 14'h0020, 16'h5555);
        txn(3, '0, 1, 16'h0, g);
        chk("store_keeps_rdata", rdata, 16'h1234);

        // timeout then a late response that must be ignored
        tick();
        set_req(0, 0, 1, 14'h0100, 16'h0);
        txn(100, '0, 0, 16'hAAAA, g);
        mem_resp = 1'b1;
        datafrommem = 16'hDEAD;
        tick();
        chk("late_rdata", rdata, 16'h1234);
        chk("late_busy", busy, 0);
        chk("late_done", done, 0);
        mem_resp = 1'b0;

        // illegal request: both store and load on one channel
        set_req(0, 1, 1, 14'h0042, 16'h4242);
        txn(1, '0, 0, 16'h0, g);
        chk("ill_rdata", rdata, 16'h1234);

        // reset asserted mid-WAIT
        tick();
        set_req(0, 0, 1, 14'h0055, 16'h0);
        tick();
        tick();
        #3;
        reset = 1'b1;
        #1;
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_outs", {write_req, read_req, done, err}, 0);
        chk("mid_rst_rdata", rdata, 0);
        chk("mid_rst_addr", addrout, 0);
        chk("mid_rst_dtm", datatomem, 0);
        store = '0; load = '0;
        rr_m = 0; rdata_m = '0;
        tick();
        reset = 1'b0;
        tick();
        chk("post_rst_done", done, 0);
        chk("post_rst_busy", busy, 0);

        // round robin from reset: both request together
        set_req(0, 1, 0, 14'h0001, 16'h1111);
        set_req(1, 0, 1, 14'h0002, 16'h0);
        txn(1, '0, 0, 16'h2222, g);
        chk("rr_first", g, 0);
        tick();
        txn(2, '0, 0, 16'h3333, g);
        chk("rr_second", g, 1);
        tick();
        set_req(0, 0, 1, 14'h0003, 16'h0);
        set_req(1, 1, 0, 14'h0004, 16'h4444);
        txn(1, '0, 0, 16'h5555, g);
        chk("rr_again_first", g, 0);
        tick();
        txn(1, '0, 0, 16'h0, g);
        chk("rr_again_second", g, 1);

        // ch1 held continuously, ch0 pulsed: strict alternation
        tick();
        set_req(1, 0, 1, 14'h0111, 16'h0);
        for (int i = 0; i < 6; i++) begin
            if (!store[0]) set_req(0, 1, 0, AW'(i), DW'($urandom));
            txn(1 + (i % 3), 2'b10, 0, DW'($urandom), g);
            chk("rr_alternate", g, i % 2);
            tick();
        end
        store = '0; load = '0;
        tick();

        // randomized traffic; waiting channels keep their requests
        for (int n = 0; n < 40; n++) begin
            for (int ch = 0; ch < NCH; ch++) begin
                if (!(store[ch] || load[ch]) && ($urandom % 2 == 1)) begin
                    r = int'($urandom % 10);
                    set_req(ch, r <= 4, (r == 0) || (r >= 5), AW'($urandom), DW'($urandom));
                end
            end
            if ((store | load) == '0) begin
                r = int'($urandom % NCH);
                set_req(r, 0, 1, AW'($urandom), DW'($urandom));
            end
            dly = int'($urandom_range(1, 7));
            txn(dly, '0, ($urandom % 4) == 0, DW'($urandom), g);
            tick();
        end

        store = '0; load = '0;
        tick();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
